// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiplier: RISC-V M-extension multiply
// ops and the controller states.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MULTIPLY = 2'b01,
        CORRECT  = 2'b11
    } state_e;

    function automatic logic op_a_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/multiplication_unit_if.sv
// Request/response bundle between a multiply requester and multiplication_unit.
interface multiplication_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic [1:0]      op;
    logic            data_valid;
    logic [XLEN-1:0] result;
    logic            data_ready;
    logic            busy;

    modport master (
        output multiplicand, multiplier, op, data_valid,
        input  result, data_ready, busy
    );

    modport slave (
        input  multiplicand, multiplier, op, data_valid,
        output result, data_ready, busy
    );
endinterface

// File: rtl/multiplication_unit.sv
// Radix-2 shift-add multiplier: one partial product per cycle on operand
// magnitudes, sign restored in a final correction cycle.
module multiplication_unit
    import mul_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = $clog2(XLEN)
) (
    input  logic                 CLK,
    input  logic                 rst,
    multiplication_unit_if.slave bus
);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [XLEN-1:0]        mcand_q, mcand_d;
    logic [XLEN-1:0]        mplier_q, mplier_d;
    logic [2*XLEN-1:0]      acc_q, acc_d;
    logic                   sign_q, sign_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]        result_q, result_d;
    logic                   ready_q, ready_d;

    logic                   a_neg, b_neg;
    logic [XLEN:0]          sum;
    logic [2*XLEN-1:0]      prod;

    // Operand signs only matter where the requested op treats them as signed.
    assign a_neg = op_a_signed(op_e'(bus.op)) && bus.multiplicand[XLEN-1];
    assign b_neg = op_b_signed(op_e'(bus.op)) && bus.multiplier[XLEN-1];

    // Carry out of the high-half add is kept and shifted back in.
    assign sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign prod = sign_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    op_d     = op_e'(bus.op);
                    mcand_d  = a_neg ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
                    mplier_d = b_neg ? (~bus.multiplier + 1'b1) : bus.multiplier;
                    sign_d   = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MULTIPLY;
                end
            end
            MULTIPLY: begin
                acc_d    = {sum, acc_q[XLEN-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result     = result_q;
    assign bus.data_ready = ready_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_multiplication_unit.sv
// Scoreboard bench for multiplication_unit: directed cases plus a random
// stream checked against a 64-bit arithmetic reference model.
module tb_multiplication_unit;

    localparam int XLEN    = 32;
    localparam int LATENCY = XLEN + 2;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    multiplication_unit_if #(.XLEN(XLEN)) bus ();

    multiplication_unit #(.XLEN(XLEN)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: sign/zero-extend to 64 bits and take the requested word.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [63:0] ea, eb, full;
        ea   = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb   = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        full = ea * eb;
        return (op == 2'b00) ? full[31:0] : full[63:32];
    endfunction

    // Issue one request; expected result pushed with the cycle valid was presented.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] expv);
        int waited = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles", bus.busy, waited);
        end
        bus.op           = op;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.data_valid   = 1'b1;
        sb.push_back('{res: expv, cyc: cyc});
        @(negedge clk);
        bus.data_valid   = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.op           = 2'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.data_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ready: data_ready=1 result=0x%08h with no request pending (cycle %0d)",
                         bus.result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("latency", XLEN'(cyc - e.cyc), XLEN'(LATENCY));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XLEN-1:0] a, b;
        logic [1:0]      op;
        logic [XLEN-1:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h7FFF_FFFF;

        bus.data_valid   = 1'b0;
        bus.op           = 2'b00;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_result", bus.result, '0);
        check("reset_ready", XLEN'(bus.data_ready), '0);
        check("reset_busy", XLEN'(bus.busy), '0);
        rst = 1'b0;

        issue(2'b00, 32'd6, 32'd7, 32'h0000_002A);
        drain();
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        issue(2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        drain();

        // A request raised mid-operation must be dropped entirely.
        issue(2'b00, 32'd9, 32'd11, 32'd99);
        repeat (9) @(negedge clk);
        bus.op = 2'b00; bus.multiplicand = 32'd5; bus.multiplier = 32'd5; bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        drain();
        repeat (LATENCY + 4) @(negedge clk);

        // Reset part way through MULTIPLY aborts without a completion pulse.
        issue(2'b00, 32'd6, 32'd7, 32'h0000_002A);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort_result", bus.result, '0);
        check("abort_ready", XLEN'(bus.data_ready), '0);
        check("abort_busy", XLEN'(bus.busy), '0);
        repeat (LATENCY + 4) @(negedge clk);
        issue(2'b00, 32'd3, 32'd4, 32'h0000_000C);
        drain();

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            issue(op, a, b, ref_mul(op, a, b));
            repeat ($urandom_range(0, 2) * 12) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
